// File: rtl/serial_adder_seq_pkg.sv
// rtl/serial_adder_seq_pkg.sv - shared constants, state type and slice-count helper
// Contents: SLICE_W (bits per Adder16 pass), state_e {IDLE, RUN, DONE},
//           slices_of(width) returning the number of passes for a width.
package serial_adder_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int slices_of(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/serial_adder_seq_adder16.sv
// rtl/serial_adder_seq_adder16.sv - 16-bit combinational adder with carry in/out
// Ports: a_i, b_i  16-bit addends
//        c_i       carry into bit 0
//        s_o       16-bit sum
//        c_o       carry out of bit 15
module serial_adder_seq_adder16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        c_i,
  output logic [15:0] s_o,
  output logic        c_o
);

  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {16'b0, c_i};

endmodule

// File: rtl/serial_adder_seq.sv
// rtl/serial_adder_seq.sv - multi-cycle WIDTH-bit adder built on one shared Adder16
// Ports: clk, rst (async, active-high)
//        start, a, b, c_in   request and operands, captured when start is accepted
//        busy                high while slices are computed
//        done                one-cycle pulse when sum/c_out/overflow are updated
//        sum, c_out, overflow registered result, held until the next completion
// WIDTH must be a multiple of 16 and at least 32.
module serial_adder_seq
  import serial_adder_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int SLICES = slices_of(WIDTH);
  localparam int IDX_W  = $clog2(SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, c_out_q, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q;

  logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic               slice_c;
  logic               accept;

  // Start is honoured only outside RUN, so an operation in flight is never disturbed.
  assign accept = start && (state_q != RUN);

  assign slice_a = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
  assign slice_b = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

  serial_adder_seq_adder16 u_adder16 (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // Working value with the current slice merged in; on the last slice this is the full sum.
  always_comb begin
    work_d = work_q;
    work_d[int'(idx_q) * SLICE_W +: SLICE_W] = slice_s;
    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= c_in;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      work_q  <= work_d;
      carry_q <= slice_c;
      idx_q   <= idx_q + IDX_W'(1);
      if (idx_q == LAST_IDX) begin
        sum_q   <= work_d;
        c_out_q <= slice_c;
        ovf_q   <= ovf_d;
      end
    end
  end

  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb/tb_serial_adder_seq.sv - scoreboard bench for serial_adder_seq
module tb_serial_adder_seq;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         c_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, overflow;
  logic [W-1:0] sum;

  serial_adder_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the oldest expectation on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", sum, e.s);
          chk("c_out", c_out, e.c);
          chk("overflow", overflow, e.o);
          chk("latency", cyc - e.acc, 4);
          chk("busy_cycles", busy_cnt, 4);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = av; b = bv; c_in = cv; start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{es, ec, eo, cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_c_out", c_out, 0);
    chk("reset_overflow", overflow, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0);
    wait_drain("carry_all");
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    wait_drain("ovf_pos");
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
    wait_drain("ovf_neg");
    issue(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    wait_drain("c_in_chain");

    // Start pulse with new operands while RUN must be ignored.
    issue(64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h0F0F_0F0F_0F0F_0F0F; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore_start");
    @(negedge clk);
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_done", done, 0);
    repeat (6) @(negedge clk);

    // Reset after two slices retire: outputs clear at once and no done appears.
    issue(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_c_out", c_out, 0);
    chk("abort_overflow", overflow, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0);
    wait_drain("after_reset");
    repeat (2) @(negedge clk);

    // Back-to-back: start held high across the DONE cycle.
    @(negedge clk);
    a = 64'h1; b = 64'h2; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{64'h3, 1'b0, 1'b0, cyc});
    @(negedge clk);
    a = 64'h3; b = 64'h4;
    repeat (5) @(posedge clk);
    #1;
    sb.push_back('{64'h7, 1'b0, 1'b0, cyc});
    @(negedge clk);
    start = 1'b0;
    wait_drain("back_to_back");
    if (done_cyc.size() >= 2) begin
      chk("b2b_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 5);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL b2b_spacing: got %0d done pulses, expected at least 2", done_cyc.size());
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
